// File: rtl/hilo_mdu_if.sv
// rtl/hilo_mdu_if.sv - pipeline-side bundle for the HI/LO multiply/divide unit
interface hilo_mdu_if #(
    parameter int WIDTH = 32
) ();
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output stall_o, busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - HI/LO multiply/divide unit, radix-2 iterative mul/div with flush abort
// Optional single-cycle MULT/MULTU when HILO_MDU_FAST_MULT_EN is defined.
module hilo_mdu #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst,
    hilo_mdu_if.slave mdu
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, op_b;
    logic [CNT_W-1:0] cnt;
    logic             is_div, neg_q, neg_r;

    logic             stall, busy, done;
    logic             accept, iter_op, last_step;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod, prod_fin;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, div_hi, div_lo;
    logic [WIDTH-1:0]   res_hi, res_lo;
`ifdef HILO_MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod, fast_res;
`endif

    // Signed ops (MULT, DIV) have op_i[0] clear; magnitudes feed an unsigned datapath.
    always_comb begin
        sa        = ~mdu.op_i[0] & mdu.a_i[WIDTH-1];
        sb        = ~mdu.op_i[0] & mdu.b_i[WIDTH-1];
        mag_a     = sa ? -mdu.a_i : mdu.a_i;
        mag_b     = sb ? -mdu.b_i : mdu.b_i;
        accept    = mdu.start_i & ~mdu.flush_i;
`ifdef HILO_MDU_FAST_MULT_EN
        iter_op   = (mdu.op_i == 3'd2) || (mdu.op_i == 3'd3);
        fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        fast_res  = (sa ^ sb) ? -fast_prod : fast_prod;
`else
        iter_op   = ~mdu.op_i[2];
`endif
        last_step = (cnt == CNT_W'(WIDTH - 1));
    end

    // One radix-2 step: shift-add multiply in {acc_hi,acc_lo}, restoring divide
    // with acc_hi as partial remainder and acc_lo shifting dividend out / quotient in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
        prod      = {mul_sum, acc_lo[WIDTH-1:1]};
        prod_fin  = neg_q ? -prod : prod;
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, op_b};
        div_diff  = div_shift[WIDTH-1:0] - op_b;
        div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_lo    = {acc_lo[WIDTH-2:0], div_ge};
        if (is_div) begin
            res_hi = neg_r ? -div_hi : div_hi;
            res_lo = neg_q ? -div_lo : div_lo;
        end else begin
            res_hi = prod_fin[2*WIDTH-1:WIDTH];
            res_lo = prod_fin[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && iter_op) begin
                    stall     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (mdu.flush_i)    state_nxt = IDLE;
                else if (last_step) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            op_b   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && iter_op) begin
                        acc_hi <= '0;
                        acc_lo <= mag_a;
                        op_b   <= mag_b;
                        cnt    <= '0;
                        is_div <= mdu.op_i[1];
                        // A zero divisor keeps the all-ones quotient unsigned.
                        neg_q  <= (sa ^ sb) & ~(mdu.op_i[1] & (mdu.b_i == '0));
                        neg_r  <= sa;
                    end else if (accept) begin
                        case (mdu.op_i)
                            3'd4: hi_q <= mdu.a_i;
                            3'd5: lo_q <= mdu.a_i;
`ifdef HILO_MDU_FAST_MULT_EN
                            3'd0, 3'd1: {hi_q, lo_q} <= fast_res;
`endif
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (!mdu.flush_i) begin
                        acc_hi <= is_div ? div_hi : prod[2*WIDTH-1:WIDTH];
                        acc_lo <= is_div ? div_lo : prod[WIDTH-1:0];
                        cnt    <= cnt + 1'b1;
                        if (last_step) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mdu.stall_o = stall;
    assign mdu.busy_o  = busy;
    assign mdu.done_o  = done;
    assign mdu.hi_o    = hi_q;
    assign mdu.lo_o    = lo_q;
endmodule
